// File: rtl/smart_home_cfg_loader.sv
// Serial configuration front end for the smart home controller.
// Hunts for a sync byte, shifts in an LSB-first payload (password, confdata,
// even parity) and, on a clean frame, loads the outputs. It then runs the
// request -> gap -> confirm handshake toward the control unit. Frames with bad
// parity or stalled frames are dropped with a one-cycle error pulse, and the
// last good configuration is kept.
module smart_home_cfg_loader #(
  parameter int          DATA_W  = 35,
  parameter int          KEY_W   = 2,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int          GAP     = 4,
  parameter int          TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              rx_bit,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [KEY_W-1:0]  password,
  output logic [DATA_W-1:0] confdata,
  output logic              request,
  output logic              confirm,
  output logic              busy,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic [7:0]        frm_cnt
);

  localparam int PAY_W  = KEY_W + DATA_W;
  localparam int BIT_W  = $clog2(PAY_W + 2);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP + 1) : 1;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    PAYLOAD = 3'd1,
    REQ     = 3'd2,
    WAIT    = 3'd3,
    CONF    = 3'd4
  } state_t;

  state_t              state_reg;
  logic [7:0]          sr_reg;
  logic [PAY_W-1:0]    shadow_reg;
  logic                par_reg;
  logic [BIT_W-1:0]    bit_cnt_reg;
  logic [IDLE_W-1:0]   idle_cnt_reg;
  logic [GAP_W-1:0]    gap_cnt_reg;

  logic [7:0]          sr_next;
  logic                accept;

  // Input is only consumed while hunting or receiving; the handshake phases stall it.
  assign rx_ready = (state_reg == HUNT) || (state_reg == PAYLOAD);
  assign busy     = (state_reg != HUNT);
  assign accept   = rx_valid && rx_ready;
  assign sr_next  = {sr_reg[6:0], rx_bit};

  // Frame receiver, handshake sequencer and all registered outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg    <= HUNT;
      sr_reg       <= '0;
      shadow_reg   <= '0;
      par_reg      <= 1'b0;
      bit_cnt_reg  <= '0;
      idle_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      password     <= '0;
      confdata     <= '0;
      request      <= 1'b0;
      confirm      <= 1'b0;
      frame_err    <= 1'b0;
      err_code     <= 2'b00;
      frm_cnt      <= 8'd0;
    end else begin
      request   <= 1'b0;
      confirm   <= 1'b0;
      frame_err <= 1'b0;
      case (state_reg)
        HUNT: begin
          if (accept) begin
            // Match on the freshly shifted window so overlapping patterns lock early.
            if (sr_next == SYNC) begin
              state_reg    <= PAYLOAD;
              sr_reg       <= '0;
              bit_cnt_reg  <= '0;
              idle_cnt_reg <= '0;
              par_reg      <= 1'b0;
            end else begin
              sr_reg <= sr_next;
            end
          end
        end
        PAYLOAD: begin
          if (accept) begin
            idle_cnt_reg <= '0;
            if (bit_cnt_reg == BIT_W'(PAY_W)) begin
              // This is the parity bit: commit or drop the whole frame.
              if ((par_reg ^ rx_bit) == 1'b0) begin
                password  <= shadow_reg[KEY_W-1:0];
                confdata  <= shadow_reg[PAY_W-1:KEY_W];
                frm_cnt   <= frm_cnt + 8'd1;
                request   <= 1'b1;
                state_reg <= REQ;
              end else begin
                frame_err <= 1'b1;
                err_code  <= 2'b01;
                state_reg <= HUNT;
              end
            end else begin
              // LSB-first: shifting right leaves the first bit at index 0 once full.
              shadow_reg  <= {rx_bit, shadow_reg[PAY_W-1:1]};
              par_reg     <= par_reg ^ rx_bit;
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else if (idle_cnt_reg == IDLE_W'(TIMEOUT - 1)) begin
            frame_err <= 1'b1;
            err_code  <= 2'b10;
            state_reg <= HUNT;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
          end
        end
        REQ: begin
          gap_cnt_reg <= '0;
          state_reg   <= WAIT;
        end
        WAIT: begin
          if (gap_cnt_reg == GAP_W'(GAP - 1)) begin
            confirm   <= 1'b1;
            state_reg <= CONF;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        CONF: begin
          state_reg <= HUNT;
        end
        default: begin
          state_reg <= HUNT;
        end
      endcase
    end
  end

endmodule
